// File: rtl/chess_board_rgb_if.sv
// chess_board_rgb_if: pixel timing and button inputs, RGB565 pixel output and cursor position.
interface chess_board_rgb_if;
  logic       DE;
  logic       Vsync;
  logic       Left;
  logic       Up;
  logic       Down;
  logic       Right;
  logic [4:0] R;
  logic [5:0] G;
  logic [4:0] B;
  logic       de_q;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  modport master (
    output DE, Vsync, Left, Up, Down, Right,
    input  R, G, B, de_q, cursor_x, cursor_y
  );
  modport slave (
    input  DE, Vsync, Left, Up, Down, Right,
    output R, G, B, de_q, cursor_x, cursor_y
  );
endinterface

// File: rtl/chess_board_rgb.sv
// chess_board_rgb: 8x8 chess board renderer with a button-driven cursor square outlined in red.
module chess_board_rgb #(
  parameter int SQ        = 32,
  parameter int BX0       = 112,
  parameter int BY0       = 8,
  parameter int DB_CYCLES = 262144
) (
  input  logic             clk,
  input  logic             rst,
  chess_board_rgb_if.slave io
);
  localparam int LS = $clog2(SQ);
  localparam int CW = $clog2(DB_CYCLES);
  typedef enum logic {STABLE, COUNTING} db_state_t;
  logic [9:0]    x;
  logic [8:0]    y;
  logic          de_d, vs_d;
  logic          vs_fall, de_fall;
  logic [9:0]    fx;
  logic [8:0]    fy;
  logic [2:0]    file, rank;
  logic [LS-1:0] ox, oy;
  logic          on_board, near_edge, is_cursor;
  logic [15:0]   col, rgb;
  logic [2:0]    cx, cy;
  logic [3:0]    raw, s1, s2, req, pend;
  assign vs_fall = vs_d & ~io.Vsync;
  assign de_fall = de_d & ~io.DE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x    <= '0;
      y    <= '0;
      de_d <= 1'b0;
      vs_d <= 1'b0;
    end else begin
      x    <= io.DE ? x + 10'd1 : '0;
      y    <= vs_fall ? '0 : de_fall ? y + 9'd1 : y;
      de_d <= io.DE;
      vs_d <= io.Vsync;
    end
  // Square index and in-square offset come straight from the bits of the board-relative position.
  assign fx        = x - 10'(BX0);
  assign fy        = y - 9'(BY0);
  assign file      = 3'(fx >> LS);
  assign rank      = 3'(fy >> LS);
  assign ox        = LS'(fx);
  assign oy        = LS'(fy);
  assign on_board  = (x >= 10'(BX0)) && (x < 10'(BX0 + 8*SQ)) && (y >= 9'(BY0)) && (y < 9'(BY0 + 8*SQ));
  assign near_edge = (ox < LS'(2)) || (ox > LS'(SQ-3)) || (oy < LS'(2)) || (oy > LS'(SQ-3));
  assign is_cursor = (file == cx) && (rank == cy);
  assign col = !on_board              ? 16'h0000 :
               is_cursor && near_edge ? 16'hF800 :
               (file[0] == rank[0])   ? 16'hEF5B : 16'h8B26;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rgb     <= '0;
      io.de_q <= 1'b0;
    end else begin
      rgb     <= io.DE ? col : '0;
      io.de_q <= io.DE;
    end
  assign io.R = rgb[15:11];
  assign io.G = rgb[10:5];
  assign io.B = rgb[4:0];
  assign raw = {io.Right, io.Down, io.Up, io.Left};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  for (genvar i = 0; i < 4; i++) begin : g_db
    db_state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic lvl, lvl_n;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st  <= STABLE;
        cnt <= '0;
        lvl <= 1'b0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
        lvl <= lvl_n;
      end
    // Entering COUNTING already accounts for the first differing cycle, so the level flips after exactly DB_CYCLES.
    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      lvl_n = lvl;
      if (st == STABLE) begin
        if (s2[i] != lvl) begin
          st_n  = COUNTING;
          cnt_n = CW'(1);
        end
      end else if (s2[i] == lvl) begin
        st_n  = STABLE;
        cnt_n = '0;
      end else if (cnt == CW'(DB_CYCLES-1)) begin
        st_n  = STABLE;
        cnt_n = '0;
        lvl_n = s2[i];
      end else
        cnt_n = cnt + 1'b1;
    end
    assign req[i] = lvl_n & ~lvl;
  end
  function automatic logic [2:0] step(input logic [2:0] v, input logic dec, input logic inc);
    return (dec == inc) ? v : dec ? ((v == 3'd0) ? v : v - 3'd1) : ((v == 3'd7) ? v : v + 3'd1);
  endfunction
  // Moves are only applied at the frame boundary; a request landing on that edge waits a frame.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend <= '0;
      cx   <= '0;
      cy   <= '0;
    end else if (vs_fall) begin
      pend <= req;
      cx   <= step(cx, pend[0], pend[3]);
      cy   <= step(cy, pend[1], pend[2]);
    end else
      pend <= pend | req;
  assign io.cursor_x = cx;
  assign io.cursor_y = cy;
endmodule

// File: tb/tb_chess_board_rgb.sv
// tb_chess_board_rgb: directed stimulus with a per-cycle behavioural model of the board renderer and cursor.
module tb_chess_board_rgb;
  localparam int DB = 16;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int line_no, cur_px, cur_py;
  logic [15:0] seen [0:270][0:399];
  chess_board_rgb_if bus();
  chess_board_rgb #(.DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] colour(input int px, input int py, input int cx, input int cy);
    int f, r, ox, oy;
    if (px < 112 || px >= 112 + 8*32 || py < 8 || py >= 8 + 8*32) return 16'h0000;
    f = (px - 112) / 32;
    r = (py - 8) / 32;
    ox = (px - 112) % 32;
    oy = (py - 8) % 32;
    if (f == cx && r == cy && (ox < 2 || ox >= 30 || oy < 2 || oy >= 30)) return 16'hF800;
    return ((f + r) % 2 == 0) ? 16'hEF5B : 16'h8B26;
  endfunction

  function automatic int mv(input int v, input bit dec, input bit inc);
    if (dec == inc) return v;
    if (dec) return (v > 0) ? v - 1 : 0;
    return (v < 7) ? v + 1 : 7;
  endfunction

  // Model: buttons seen two clocks late, a press counts once it has held DB clocks, moves land at Vsync fall.
  logic [3:0] raw_h1, raw_h2, lvl_m, pend_m;
  int run_m [4];
  int mcx, mcy;
  logic vs_prev_m;
  always @(posedge clk) begin
    logic [3:0] raw, rq;
    logic de_s, vs_s, rst_s, e_de;
    logic [15:0] e_rgb;
    int px, py;
    raw = {bus.Right, bus.Down, bus.Up, bus.Left};
    de_s = bus.DE;
    vs_s = bus.Vsync;
    rst_s = rst;
    px = cur_px;
    py = cur_py;
    if (rst_s) begin
      raw_h1 = '0; raw_h2 = '0; lvl_m = '0; pend_m = '0;
      for (int b = 0; b < 4; b++) run_m[b] = 0;
      mcx = 0; mcy = 0; vs_prev_m = 1'b0;
      e_de = 1'b0; e_rgb = '0;
    end else begin
      e_de = de_s;
      e_rgb = de_s ? colour(px, py, mcx, mcy) : 16'h0000;
      rq = '0;
      for (int b = 0; b < 4; b++)
        if (raw_h2[b] != lvl_m[b]) begin
          run_m[b]++;
          if (run_m[b] == DB) begin
            lvl_m[b] = raw_h2[b];
            run_m[b] = 0;
            rq[b] = raw_h2[b];
          end
        end else run_m[b] = 0;
      if (vs_prev_m && !vs_s) begin
        mcx = mv(mcx, pend_m[0], pend_m[3]);
        mcy = mv(mcy, pend_m[1], pend_m[2]);
        pend_m = rq;
      end else pend_m = pend_m | rq;
      raw_h2 = raw_h1;
      raw_h1 = raw;
      vs_prev_m = vs_s;
    end
    #1;
    chk("de_q", 32'(bus.de_q), 32'(e_de));
    chk("rgb", 32'({bus.R, bus.G, bus.B}), 32'(e_rgb));
    chk("cursor_x", 32'(bus.cursor_x), 32'(mcx));
    chk("cursor_y", 32'(bus.cursor_y), 32'(mcy));
    if (e_de && !rst_s && px < 400 && py < 271) seen[py][px] = {bus.R, bus.G, bus.B};
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.DE = 1'b1;
      cur_px = i;
      cur_py = line_no;
    end
    @(negedge clk);
    bus.DE = 1'b0;
    line_no++;
    idle(3);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    bus.Vsync = 1'b0;
    line_no = 0;
    idle(3);
    bus.Vsync = 1'b1;
    idle(2);
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    {bus.Right, bus.Down, bus.Up, bus.Left} = b;
    idle(25);
    {bus.Right, bus.Down, bus.Up, bus.Left} = 4'b0000;
    idle(30);
  endtask

  initial begin
    rst = 1'b1;
    bus.DE = 1'b0; bus.Vsync = 1'b1;
    bus.Left = 1'b0; bus.Up = 1'b0; bus.Down = 1'b0; bus.Right = 1'b0;
    line_no = 0; cur_px = 0; cur_py = 0;
    idle(3);
    chk("reset_de_q", 32'(bus.de_q), 32'd0);
    chk("reset_rgb", 32'({bus.R, bus.G, bus.B}), 32'd0);
    chk("reset_cursor", 32'({bus.cursor_x, bus.cursor_y}), 32'd0);
    chk("model_border_00", 32'(colour(112, 8, 0, 0)), 32'hF800);
    chk("model_dark", 32'(colour(150, 20, 0, 0)), 32'h8B26);
    chk("model_outside", 32'(colour(50, 20, 0, 0)), 32'h0000);
    chk("model_light", 32'(colour(144, 40, 0, 0)), 32'hEF5B);
    chk("model_border_10", 32'(colour(175, 9, 1, 0)), 32'hF800);
    rst = 1'b0;
    idle(2);
    vsync_pulse();
    for (int l = 0; l < 21; l++) pix_line(160);
    chk("px_112_8", 32'(seen[8][112]), 32'hF800);
    chk("px_150_20", 32'(seen[20][150]), 32'h8B26);
    chk("px_50_20", 32'(seen[20][50]), 32'h0000);
    chk("px_120_8", 32'(seen[8][120]), 32'hF800);
    chk("px_120_10", 32'(seen[10][120]), 32'hEF5B);
    press(4'b1000);
    chk("right_pending", 32'(bus.cursor_x), 32'd0);
    vsync_pulse();
    chk("right_applied", 32'({bus.cursor_x, bus.cursor_y}), 32'h08);
    for (int l = 0; l < 10; l++) pix_line(180);
    for (int yy = 8; yy < 10; yy++)
      for (int xx = 144; xx < 176; xx++) chk("red_row", 32'(seen[yy][xx]), 32'hF800);
    chk("old_square", 32'(seen[9][120]), 32'hEF5B);
    for (int i = 0; i < 20; i++) begin
      bus.Down = ~bus.Down;
      idle(5);
    end
    bus.Down = 1'b1;
    idle(40);
    vsync_pulse();
    chk("bounce_y", 32'(bus.cursor_y), 32'd1);
    chk("bounce_x", 32'(bus.cursor_x), 32'd1);
    bus.Down = 1'b0;
    idle(30);
    repeat (6) begin
      press(4'b1100);
      vsync_pulse();
    end
    chk("reach_77", 32'({bus.cursor_x, bus.cursor_y}), 32'h3F);
    press(4'b1100);
    vsync_pulse();
    chk("sat_77", 32'({bus.cursor_x, bus.cursor_y}), 32'h3F);
    press(4'b0001);
    vsync_pulse();
    chk("left_to_6", 32'(bus.cursor_x), 32'd6);
    press(4'b1001);
    vsync_pulse();
    chk("lr_cancel_x", 32'(bus.cursor_x), 32'd6);
    chk("lr_keep_y", 32'(bus.cursor_y), 32'd7);
    @(negedge clk);
    bus.Right = 1'b1;
    repeat (17) @(negedge clk);
    bus.Vsync = 1'b0;
    line_no = 0;
    idle(3);
    bus.Vsync = 1'b1;
    chk("coincident_held", 32'(bus.cursor_x), 32'd6);
    idle(20);
    bus.Right = 1'b0;
    idle(30);
    vsync_pulse();
    chk("coincident_next", 32'(bus.cursor_x), 32'd7);
    @(negedge clk);
    bus.Right = 1'b1;
    bus.Down = 1'b1;
    idle(25);
    bus.Down = 1'b0;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      bus.DE = 1'b1;
      cur_px = i;
      cur_py = line_no;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_de_q", 32'(bus.de_q), 32'd0);
    chk("rst_rgb", 32'({bus.R, bus.G, bus.B}), 32'd0);
    chk("rst_cursor", 32'({bus.cursor_x, bus.cursor_y}), 32'd0);
    idle(3);
    rst = 1'b0;
    line_no = 0;
    for (int i = 0; i < 20; i++) begin
      cur_px = i;
      cur_py = 0;
      bus.DE = 1'b1;
      @(negedge clk);
    end
    bus.DE = 1'b0;
    line_no = 1;
    idle(3);
    for (int l = 1; l < 12; l++) pix_line(150);
    bus.Right = 1'b0;
    idle(30);
    chk("post_rst_pending", 32'({bus.cursor_x, bus.cursor_y}), 32'd0);
    vsync_pulse();
    chk("held_through_rst_x", 32'(bus.cursor_x), 32'd1);
    chk("pend_cleared_y", 32'(bus.cursor_y), 32'd0);
    press(4'b0011);
    vsync_pulse();
    chk("to_00", 32'({bus.cursor_x, bus.cursor_y}), 32'd0);
    press(4'b0011);
    vsync_pulse();
    chk("sat_00", 32'({bus.cursor_x, bus.cursor_y}), 32'd0);
    for (int l = 0; l < 10; l++) pix_line(150);
    chk("final_border", 32'(seen[9][113]), 32'hF800);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
